id_ex_stage_reg: RTL

//  ID/EX pipeline register for the 5-stage MIPS32 core. Latches Control_Unit decode outputs plus ID operands into EX.

---
 rtl/id_ex_stage_reg.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: load-use bubble insertion, EX-flush bubbles and the halt-drain FSM.
// Optional performance counters (bubble_cnt, flush_cnt) are enabled by defining ID_EX_PERF_CNT_EN.
module id_ex_stage_reg #(
    parameter int DATA_W       = 32,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_pc,
    input  logic [DATA_W-1:0] id_rs1_data,
    input  logic [DATA_W-1:0] id_rs2_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic              id_sel2,
    input  logic              id_jump,
    input  logic              id_is_jr,
    input  logic              id_mem_wr,
    input  logic              id_mem_rd,
    input  logic              id_reg_wr,
    input  logic              id_sel4,
    input  logic              id_rs2_use,
    input  logic              id_hlt,
    input  logic [1:0]        id_branch_type,
    input  logic [5:0]        id_alu_ctrl,
    input  logic              flush_ex,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_pc,
    output logic [DATA_W-1:0] ex_rs1_data,
    output logic [DATA_W-1:0] ex_rs2_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [4:0]        ex_rs1,
    output logic [4:0]        ex_rs2,
    output logic [4:0]        ex_rd,
    output logic              ex_sel2,
    output logic              ex_jump,
    output logic              ex_is_jr,
    output logic              ex_mem_wr,
    output logic              ex_mem_rd,
    output logic              ex_reg_wr,
    output logic              ex_sel4,
    output logic              ex_rs2_use,
    output logic              ex_hlt,
    output logic [1:0]        ex_branch_type,
    output logic [5:0]        ex_alu_ctrl,
    output logic              stall_front,
`ifdef ID_EX_PERF_CNT_EN
    output logic [31:0]       bubble_cnt,
    output logic [31:0]       flush_cnt,
`endif
    output logic              halted
);

    localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_HALTED
    } state_e;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] rs1_data;
        logic [DATA_W-1:0] rs2_data;
        logic [DATA_W-1:0] imm;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
        logic              sel2;
        logic              jump;
        logic              is_jr;
        logic              mem_wr;
        logic              mem_rd;
        logic              reg_wr;
        logic              sel4;
        logic              rs2_use;
        logic              hlt;
        logic [1:0]        branch_type;
        logic [5:0]        alu_ctrl;
    } stage_t;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    stage_t           ex_q, ex_d, id_in;
    logic             run;
    logic             lu_haz;
    logic             load_id;

    always_comb begin
        id_in             = '0;
        id_in.valid       = 1'b1;
        id_in.pc          = id_pc;
        id_in.rs1_data    = id_rs1_data;
        id_in.rs2_data    = id_rs2_data;
        id_in.imm         = id_imm;
        id_in.rs1         = id_rs1;
        id_in.rs2         = id_rs2;
        id_in.rd          = id_rd;
        id_in.sel2        = id_sel2;
        id_in.jump        = id_jump;
        id_in.is_jr       = id_is_jr;
        id_in.mem_wr      = id_mem_wr;
        id_in.mem_rd      = id_mem_rd;
        id_in.reg_wr      = id_reg_wr;
        id_in.sel4        = id_sel4;
        id_in.rs2_use     = id_rs2_use;
        id_in.hlt         = id_hlt;
        id_in.branch_type = id_branch_type;
        id_in.alu_ctrl    = id_alu_ctrl;
    end

    // A load in EX whose destination is read by the ID instruction cannot be forwarded in time.
    assign lu_haz = id_valid & ex_q.valid & ex_q.mem_rd & ex_q.reg_wr & (ex_q.rd != 5'd0) &
                    ((ex_q.rd == id_rs1) | (id_rs2_use & (ex_q.rd == id_rs2)));

    assign run         = (state_q == ST_RUN);
    assign load_id     = run & ~flush_ex & ~lu_haz & id_valid;
    assign stall_front = ~run | (lu_haz & ~flush_ex);
    assign halted      = (state_q == ST_HALTED);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ex_d    = '0;
        unique case (state_q)
            ST_RUN: begin
                if (load_id) begin
                    ex_d = id_in;
                    if (id_hlt) begin
                        state_d = ST_DRAIN;
                        cnt_d   = CNT_W'(DRAIN_CYCLES);
                    end
                end
            end
            ST_DRAIN: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) state_d = ST_HALTED;
            end
            ST_HALTED: ;
            default: state_d = ST_RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            ex_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ex_q    <= ex_d;
        end
    end

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] bubble_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else if (run) begin
            if (lu_haz && !flush_ex && bubble_cnt_q != 32'hFFFF_FFFF)
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
            if (flush_ex && flush_cnt_q != 32'hFFFF_FFFF)
                flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign bubble_cnt = bubble_cnt_q;
    assign flush_cnt  = flush_cnt_q;
`endif

    assign ex_valid       = ex_q.valid;
    assign ex_pc          = ex_q.pc;
    assign ex_rs1_data    = ex_q.rs1_data;
    assign ex_rs2_data    = ex_q.rs2_data;
    assign ex_imm         = ex_q.imm;
    assign ex_rs1         = ex_q.rs1;
    assign ex_rs2         = ex_q.rs2;
    assign ex_rd          = ex_q.rd;
    assign ex_sel2        = ex_q.sel2;
    assign ex_jump        = ex_q.jump;
    assign ex_is_jr       = ex_q.is_jr;
    assign ex_mem_wr      = ex_q.mem_wr;
    assign ex_mem_rd      = ex_q.mem_rd;
    assign ex_reg_wr      = ex_q.reg_wr;
    assign ex_sel4        = ex_q.sel4;
    assign ex_rs2_use     = ex_q.rs2_use;
    assign ex_hlt         = ex_q.hlt;
    assign ex_branch_type = ex_q.branch_type;
    assign ex_alu_ctrl    = ex_q.alu_ctrl;

endmodule
